// File: rtl/poly_tone_sequencer_if.sv
// poly_tone_sequencer_if: playback control and song-table write bus for poly_tone_sequencer
interface poly_tone_sequencer_if #(
    parameter int CHANNELS = 2,
    parameter int SONG_LEN = 16,
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 8
);
    logic                            start;
    logic                            stop;
    logic                            loop_en;
    logic                            wr_en;
    logic [$clog2(SONG_LEN)-1:0]     wr_addr;
    logic [CHANNELS*DIV_W+DUR_W-1:0] wr_data;
    modport master (output start, stop, loop_en, wr_en, wr_addr, wr_data);
    modport slave  (input  start, stop, loop_en, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/poly_tone_sequencer.sv
// poly_tone_sequencer: multi-channel square-wave song sequencer; define SEQ_MIX_EN for a sigma-delta mixed output
module poly_tone_sequencer #(
    parameter int CHANNELS = 2,
    parameter int SONG_LEN = 16,
    parameter int DIV_W    = 16,
    parameter int DUR_W    = 8,
    parameter int TICK_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [TICK_W-1:0]           ticks_per_milli,
    poly_tone_sequencer_if.slave        bus,
    output logic                        busy,
    output logic [$clog2(SONG_LEN)-1:0] step,
    output logic [CHANNELS-1:0]         sound,
    output logic                        sound_mix,
    output logic [7:0]                  led
);
    localparam int SW = $clog2(SONG_LEN);
    localparam int EW = CHANNELS * DIV_W + DUR_W;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t            state;
    logic [EW-1:0]     table_mem [SONG_LEN];
    logic [EW-1:0]     entry;
    logic [DIV_W-1:0]  div [CHANNELS];
    logic [DIV_W-1:0]  tone_cnt [CHANNELS];
    logic [DUR_W-1:0]  dur;
    logic [DUR_W-1:0]  ms_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_max;
    logic [TICK_W-1:0] t_last;
    logic              ms_wrap;
    logic              note_end;
    logic              play_on;
    logic [CHANNELS-1:0] tone_nxt;
    logic [CHANNELS-1:0] snd_nxt;

    assign entry    = table_mem[step];
    assign t_last   = ticks_per_milli == '0 ? '0 : ticks_per_milli - TICK_W'(1);
    assign ms_wrap  = tick_cnt == tick_max;
    assign note_end = ms_wrap && ms_cnt == dur - DUR_W'(1);
    assign play_on  = state == PLAY && !note_end && !bus.stop;
    assign snd_nxt  = play_on ? tone_nxt : '0;
    assign led      = {busy, 7'(step)};

    // Song table: plain register array, written whenever strobed, never reset
    always_ff @(posedge clk) begin
        if (bus.wr_en) table_mem[bus.wr_addr] <= bus.wr_data;
    end

    // Each sounding channel flips when its half-period counter reaches div-1; rests hold 0
    always_comb begin
        tone_nxt = sound;
        for (int c = 0; c < CHANNELS; c++)
            tone_nxt[c] = div[c] != '0 && tone_cnt[c] == div[c] - DIV_W'(1) ? !sound[c] : sound[c];
    end

    // Sequencer FSM with tick/ms/tone counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            step     <= '0;
            sound    <= '0;
            dur      <= '0;
            ms_cnt   <= '0;
            tick_cnt <= '0;
            tick_max <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                div[c]      <= '0;
                tone_cnt[c] <= '0;
            end
        end else begin
            sound <= snd_nxt;
            if (bus.stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                step  <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                        step  <= '0;
                    end
                    FETCH: begin
                        dur      <= entry[DUR_W-1:0];
                        ms_cnt   <= '0;
                        tick_cnt <= '0;
                        tick_max <= t_last;
                        for (int c = 0; c < CHANNELS; c++) begin
                            div[c]      <= entry[DUR_W + c*DIV_W +: DIV_W];
                            tone_cnt[c] <= '0;
                        end
                        if (entry[DUR_W-1:0] == '0) begin
                            state <= bus.loop_en ? FETCH : IDLE;
                            busy  <= bus.loop_en;
                            step  <= '0;
                        end else begin
                            state <= PLAY;
                        end
                    end
                    PLAY: begin
                        tick_cnt <= ms_wrap ? '0 : tick_cnt + TICK_W'(1);
                        if (ms_wrap) begin
                            tick_max <= t_last;
                            ms_cnt   <= ms_cnt + DUR_W'(1);
                        end
                        for (int c = 0; c < CHANNELS; c++)
                            tone_cnt[c] <= tone_cnt[c] == div[c] - DIV_W'(1) ? '0 : tone_cnt[c] + DIV_W'(1);
                        if (note_end) begin
                            if (step == SW'(SONG_LEN - 1)) begin
                                state <= bus.loop_en ? FETCH : IDLE;
                                busy  <= bus.loop_en;
                                step  <= '0;
                            end else begin
                                state <= FETCH;
                                step  <= step + SW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        step  <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_MIX_EN
    localparam int AW = $clog2(CHANNELS) + 1;
    logic [AW-1:0] acc;
    logic [AW-1:0] mix_sum;

    // Add this cycle's count of high voices onto the error accumulator
    always_comb begin
        mix_sum = acc;
        for (int c = 0; c < CHANNELS; c++) mix_sum = mix_sum + AW'(snd_nxt[c]);
    end

    // First-order sigma-delta: emit 1 whenever a full CHANNELS quantum has built up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            sound_mix <= 1'b0;
        end else if (play_on) begin
            acc       <= mix_sum >= AW'(CHANNELS) ? mix_sum - AW'(CHANNELS) : mix_sum;
            sound_mix <= mix_sum >= AW'(CHANNELS);
        end else begin
            acc       <= '0;
            sound_mix <= 1'b0;
        end
    end
`else
    // Without mixing the speaker output simply mirrors channel 0 with the same timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sound_mix <= 1'b0;
        else        sound_mix <= snd_nxt[0];
    end
`endif
endmodule

// File: doc/poly_tone_sequencer.md
# poly_tone_sequencer

Multi-channel, parametrised song sequencer: plays a writable song table of chords, one square-wave tone generator per channel, note durations in milliseconds derived from a runtime `ticks_per_milli`. It sits directly under the TinyTapeout top. `sound[0]` or `sound_mix` drives the speaker pin, and `led` drives the 7-segment/LED outputs. It is the successor to the single-voice fixed-song music processor: it adds channel count, a loadable song table, a loop mode and a mixed output.

## Interface
Parameters:
- `CHANNELS`, 2 — number of simultaneous tone channels (1..4).
- `SONG_LEN`, 16 — song table depth in entries (power of two, 2..64).
- `DIV_W`, 16 — per-channel half-period divider width (cycles).
- `DUR_W`, 8 — duration field width (ms).
- `TICK_W`, 16 — width of `ticks_per_milli`.

Ports:
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `ticks_per_milli`  in  TICK_W  — clock cycles per millisecond. Sampled continuously; 0 is treated as 1.
- `start`  in  1  — pulse; begins playback at entry 0 when idle, ignored when busy.
- `stop`  in  1  — aborts playback. Wins over `start` in the same cycle.
- `loop_en`  in  1  — at song end, restart at entry 0 instead of going idle.
- `wr_en`  in  1  — song table write strobe.
- `wr_addr`  in  $clog2(SONG_LEN)  — table write address.
- `wr_data`  in  CHANNELS*DIV_W+DUR_W  — entry: `{div[CHANNELS-1]..div[0], dur}`, with `dur` in the LSBs.
- `busy`  out  1  — high while not IDLE.
- `step`  out  $clog2(SONG_LEN)  — index of the entry being played.
- `sound`  out  CHANNELS  — per-channel square waves.
- `sound_mix`  out  1  — mixed output (see Configuration).
- `led`  out  8  — `{busy, 0.., step}`: `step` zero-extended into `led[6:0]`, `led[7]=busy`.

## Operation
- The song table is a SONG_LEN-entry register array. It is written synchronously whenever `wr_en`=1 and the write is always accepted. It is not cleared by reset; its contents after reset are undefined until written.
- FSM states: IDLE, FETCH, PLAY.
  - IDLE --`start`&!`stop`--> FETCH with `step`=0.
  - FETCH lasts 1 cycle. It latches table[`step`] into the current-entry registers and clears all tone and ms counters.
    - If latched `dur`=0, the entry is the end marker: go to FETCH with `step`=0 if `loop_en`, else IDLE.
    - Otherwise go to PLAY.
  - PLAY: the tick counter counts max(T,1) cycles per ms, and the ms counter counts `dur` ms. On expiry:
    - if `step`=SONG_LEN-1, treat as song end (same rule as the end marker);
    - else increment `step` and go to FETCH.
  - `stop`=1 in any state forces IDLE on the next edge and sets `step` to 0.
- A write to the entry currently in PLAY takes effect only at its next FETCH.
- Tone channel c: if `div[c]`=0 (rest), `sound[c]`=0. Else a counter runs 0..div[c]-1 and `sound[c]` toggles on wrap, giving period 2·div[c] cycles. The first toggle happens div[c] cycles after PLAY entry.
- `sound` is 0 in IDLE and FETCH.
- A change of `ticks_per_milli` mid-note applies from the next ms tick-counter wrap.

## Timing
- Reset values: `busy`=0, `step`=0, `sound`=0, `sound_mix`=0, `led`=0. FSM=IDLE, all counters 0.
- Latency:
  - `start` sampled at edge k → `busy`=1 after edge k (FETCH); PLAY follows at edge k+1.
  - Each entry occupies exactly 1 + dur·max(T,1) cycles.
  - An end marker costs 1 FETCH cycle. With `loop_en`=1 it then costs a further FETCH for entry 0.
- Outputs are registered, with no combinational path from inputs to outputs.
- `start` while busy is ignored. `start` and `stop` in the same cycle → IDLE.
- Reset asserted mid-note → all outputs go to reset values immediately (asynchronous). The table is preserved.

## Configuration
- `SEQ_MIX_EN` defined:
  - `sound_mix` is a first-order sigma-delta of n = number of `sound` bits high.
  - Accumulator width is $clog2(CHANNELS)+1. Each cycle acc += n; when acc ≥ CHANNELS, subtract CHANNELS and output 1; otherwise output 0.
  - The accumulator is cleared in IDLE and FETCH.
- `SEQ_MIX_EN` undefined:
  - `sound_mix` = `sound[0]`, registered identically. No accumulator is built.

## Test plan
- T=10, table[0]={div0=5,div1=0,dur=2}, table[1].dur=0, `start` → `busy` is 1 for 1+20+1 cycles. `sound[0]` toggles every 5 cycles (4 toggles during PLAY). `sound[1]`=0. `led`=0x80 during entry 0, then 0x00 after.
- T=0, table[0].dur=3, table[1].dur=0 → PLAY lasts 3 cycles (T clamped to 1).
- All 16 entries have dur=1, T=4, `loop_en`=0 → `step` goes 0..15, then IDLE after 16·5 cycles. With `loop_en`=1, `step` returns to 0 and `busy` stays 1.
- `stop` pulsed mid-PLAY at step 3 → next cycle `busy`=0, `step`=0, `sound`=0. A subsequent `start` replays from 0.
- `rst_n` low for 1 ns mid-note → outputs 0 immediately. After release, `start` replays the pre-reset table unchanged.
- `SEQ_MIX_EN`, CHANNELS=2, div0=div1=4 → `sound_mix` high every cycle while both channels are high, 0 while both are low. With div1=0, `sound_mix` alternates 1/0 while `sound[0]`=1.
